// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush scheduler beside the ID stage of the 5-stage MIPS core.
// It detects load-use hazards, sequences multi-cycle mul/div (MDU) operations with a
// watchdog, and drives the PC/IF-ID write enable, the ID/EX bubble and the IF flush.
// Build option: define DELAY_SLOT_EN when the branch delay slot is architectural;
// if_flush is then tied low. Without it, a taken branch squashes the fetched successor.
// o_dbg_state exposes the FSM state (0 = RUN, 1 = LU_STALL, 2 = MDU_WAIT).
module pipe_stall_ctrl #(
    parameter int LU_STALL_CYC = 1,
    parameter int MDU_MAX_CYC  = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_store,
    input  logic       id_mdu,
    input  logic       br_taken,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_rn,
    input  logic       mdu_done,
    output logic       wpcir,
    output logic       id_bubble,
    output logic       if_flush,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic       mdu_err,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_LU_STALL = 2'd1;
    localparam logic [1:0]  ST_MDU_WAIT = 2'd2;
    localparam logic [15:0] LU_CNT_INIT = 16'(LU_STALL_CYC - 1);
    localparam logic [15:0] MDU_LAST    = 16'(MDU_MAX_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_mdu_err;
    logic        w_mdu_err_nxt;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_lu;
    logic        w_mdu_req;
    logic        w_mdu_release;

    // MDU handshake: mdu_start is a single-cycle launch pulse issued from RUN; the unit
    // answers with a single-cycle mdu_done pulse, which is honoured only in MDU_WAIT.
    // Release happens on the done cycle itself, or when the watchdog count runs out.

    // A store needs rt only at MEM, where it is forwarded, so it never stalls on rt.
    assign w_rs_hit      = id_use_rs & (ex_rn == id_rs);
    assign w_rt_hit      = id_use_rt & (ex_rn == id_rt) & ~id_store;
    assign w_lu          = id_valid & ex_wreg & ex_m2reg & (ex_rn != 5'd0) & (w_rs_hit | w_rt_hit);
    assign w_mdu_req     = id_valid & id_mdu;
    assign w_mdu_release = mdu_done | (r_cnt >= MDU_LAST);
    assign mdu_err       = r_mdu_err;
    assign o_dbg_state   = r_state;

    // State register: FSM state, shared stall/watchdog counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_cnt     <= 16'd0;
            r_mdu_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mdu_err <= w_mdu_err_nxt;
        end
    end

    // Next-state logic: hazard priority lu > mdu, counter saturates in both directions.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_mdu_err_nxt = r_mdu_err;
        case (r_state)
            ST_RUN: begin
                if (w_lu) begin
                    // A single stall cycle needs no extra state: the bubble clears EX.
                    if (LU_STALL_CYC > 1) begin
                        w_state_nxt = ST_LU_STALL;
                        w_cnt_nxt   = LU_CNT_INIT;
                    end
                end else if (w_mdu_req) begin
                    w_state_nxt = ST_MDU_WAIT;
                    w_cnt_nxt   = 16'd0;
                end
            end
            ST_LU_STALL: begin
                w_cnt_nxt = (r_cnt != 16'd0) ? (r_cnt - 16'd1) : 16'd0;
                if (r_cnt <= 16'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_MDU_WAIT: begin
                w_cnt_nxt = (r_cnt != 16'hFFFF) ? (r_cnt + 16'd1) : r_cnt;
                if (mdu_done) begin
                    // Done wins over a coinciding watchdog expiry; error left untouched.
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt >= MDU_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = 16'd0;
                    w_mdu_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Output logic: combinational from state and inputs so a stall takes effect this cycle.
    always_comb begin
        wpcir     = 1'b1;
        id_bubble = 1'b0;
        mdu_start = 1'b0;
        mdu_busy  = 1'b0;
        if (reset) begin
            wpcir     = 1'b1;
            id_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_lu) begin
                        wpcir     = 1'b0;
                        id_bubble = 1'b1;
                    end else if (w_mdu_req) begin
                        mdu_start = 1'b1;
                        wpcir     = 1'b0;
                        id_bubble = 1'b1;
                    end
                end
                ST_LU_STALL: begin
                    wpcir     = 1'b0;
                    id_bubble = 1'b1;
                end
                ST_MDU_WAIT: begin
                    mdu_busy  = 1'b1;
                    wpcir     = w_mdu_release;
                    id_bubble = ~w_mdu_release;
                end
                default: begin
                    wpcir     = 1'b1;
                    id_bubble = 1'b0;
                end
            endcase
        end
`ifdef DELAY_SLOT_EN
        if_flush = 1'b0;
`else
        // A taken branch squashes the successor only once the pipe is advancing.
        if_flush = br_taken & wpcir & ~reset;
`endif
    end

endmodule
